// File: rtl/circle_pkg.sv
// Shared definitions for the circle statistics stage: Q16.8 format constants,
// default datapath widths and the accumulator state encoding.
package circle_pkg;

    localparam int FRAC_BITS = 8;
    localparam int AW_DEF    = 24;
    localparam int SW_DEF    = 32;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/circle_stats_acc_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on carry-out and flags it.
module sat_add #(
    parameter int SW = 32
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    output logic [SW-1:0] sum_o,
    output logic          ovf_o
);

    logic [SW:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o = full[SW];
    assign sum_o = full[SW] ? '1 : full[SW-1:0];

endmodule

// File: rtl/circle_stats_acc.sv
// Per-frame accumulator of circle area/perimeter samples with a held output record.
// Optional peak-area tracking is enabled by defining CIRCLE_STATS_MAX_EN.
module circle_stats_acc
    import circle_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int SW      = SW_DEF,
    parameter int CW      = 8,
    parameter int MAX_LEN = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [AW-1:0] area,
    input  logic [AW-1:0] perimeter,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] sum_area,
    output logic [SW-1:0] sum_perim,
    output logic [AW-1:0] max_area,
    output logic [CW-1:0] count,
    output logic          sat
);

    state_e        state_q, state_d;
    logic [SW-1:0] accArea_q, accArea_d, accPerim_q, accPerim_d;
    logic [CW-1:0] accCnt_q, accCnt_d;
    logic          accSat_q, accSat_d;
    logic [SW-1:0] outArea_q, outArea_d, outPerim_q, outPerim_d;
    logic [CW-1:0] outCnt_q, outCnt_d;
    logic          outSat_q, outSat_d;

    logic [SW-1:0] newArea, newPerim;
    logic          ovfArea, ovfPerim;
    logic [CW-1:0] newCnt;
    logic          newSat, accept, frameEnd;

    sat_add #(.SW(SW)) uAreaAdd (
        .a_i   (accArea_q),
        .b_i   (SW'(area)),
        .sum_o (newArea),
        .ovf_o (ovfArea)
    );

    sat_add #(.SW(SW)) uPerimAdd (
        .a_i   (accPerim_q),
        .b_i   (SW'(perimeter)),
        .sum_o (newPerim),
        .ovf_o (ovfPerim)
    );

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready && !clear;
    assign newCnt    = accCnt_q + 1'b1;
    assign newSat    = accSat_q || ovfArea || ovfPerim;
    // A sample carrying in_last that also reaches MAX_LEN still closes one frame.
    assign frameEnd  = accept && (in_last || (newCnt == CW'(MAX_LEN)));

    always_comb begin
        state_d    = state_q;
        accArea_d  = accArea_q;
        accPerim_d = accPerim_q;
        accCnt_d   = accCnt_q;
        accSat_d   = accSat_q;
        outArea_d  = outArea_q;
        outPerim_d = outPerim_q;
        outCnt_d   = outCnt_q;
        outSat_d   = outSat_q;
        if (clear) begin
            state_d    = ACC;
            accArea_d  = '0;
            accPerim_d = '0;
            accCnt_d   = '0;
            accSat_d   = 1'b0;
            outArea_d  = '0;
            outPerim_d = '0;
            outCnt_d   = '0;
            outSat_d   = 1'b0;
        end else if (frameEnd) begin
            state_d    = HOLD;
            outArea_d  = newArea;
            outPerim_d = newPerim;
            outCnt_d   = newCnt;
            outSat_d   = newSat;
            accArea_d  = '0;
            accPerim_d = '0;
            accCnt_d   = '0;
            accSat_d   = 1'b0;
        end else if (accept) begin
            accArea_d  = newArea;
            accPerim_d = newPerim;
            accCnt_d   = newCnt;
            accSat_d   = newSat;
        end else if (state_q == HOLD && out_ready) begin
            state_d = ACC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACC;
            accArea_q  <= '0;
            accPerim_q <= '0;
            accCnt_q   <= '0;
            accSat_q   <= 1'b0;
            outArea_q  <= '0;
            outPerim_q <= '0;
            outCnt_q   <= '0;
            outSat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            accArea_q  <= accArea_d;
            accPerim_q <= accPerim_d;
            accCnt_q   <= accCnt_d;
            accSat_q   <= accSat_d;
            outArea_q  <= outArea_d;
            outPerim_q <= outPerim_d;
            outCnt_q   <= outCnt_d;
            outSat_q   <= outSat_d;
        end
    end

`ifdef CIRCLE_STATS_MAX_EN
    logic [AW-1:0] accMax_q, accMax_d, outMax_q, outMax_d, newMax;

    // Strict compare: an equal area leaves the recorded peak untouched.
    assign newMax = (area > accMax_q) ? area : accMax_q;

    always_comb begin
        accMax_d = accMax_q;
        outMax_d = outMax_q;
        if (clear) begin
            accMax_d = '0;
            outMax_d = '0;
        end else if (frameEnd) begin
            accMax_d = '0;
            outMax_d = newMax;
        end else if (accept) begin
            accMax_d = newMax;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accMax_q <= '0;
            outMax_q <= '0;
        end else begin
            accMax_q <= accMax_d;
            outMax_q <= outMax_d;
        end
    end

    assign max_area = outMax_q;
`else
    assign max_area = '0;
`endif

    assign sum_area  = outArea_q;
    assign sum_perim = outPerim_q;
    assign count     = outCnt_q;
    assign sat       = outSat_q;

endmodule

// File: tb/tb_circle_stats_acc.sv
// Randomised self-checking bench for circle_stats_acc against a frame-level
// reference model (sample queue, clamped totals). Honours CIRCLE_STATS_MAX_EN.
module tb_circle_stats_acc;

    localparam int AW      = 24;
    localparam int SW      = 26;
    localparam int CW      = 8;
    localparam int MAX_LEN = 6;
    localparam longint SMAX = (longint'(1) << SW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [AW-1:0] area;
    logic [AW-1:0] perimeter;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] sum_area;
    logic [SW-1:0] sum_perim;
    logic [AW-1:0] max_area;
    logic [CW-1:0] count;
    logic          sat;

    int errCount   = 0;
    int checkCount = 0;

    // Reference model: samples of the open frame plus the record being held.
    longint areaQ[$];
    longint perimQ[$];
    bit     holding;
    longint expSumArea, expSumPerim, expMax, expCount;
    bit     expSat;

    circle_stats_acc #(
        .AW(AW), .SW(SW), .CW(CW), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .area(area), .perimeter(perimeter),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_area(sum_area), .sum_perim(sum_perim), .max_area(max_area),
        .count(count), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        areaQ.delete();
        perimQ.delete();
        holding = 1'b0;
    endtask

    // Closes the open frame: totals clamp at the sum ceiling, sat if either overflowed.
    task automatic modelCloseFrame();
        longint ta, tp, mx;
        ta = 0; tp = 0; mx = 0;
        foreach (areaQ[i]) begin
            ta += areaQ[i];
            tp += perimQ[i];
            if (areaQ[i] > mx) mx = areaQ[i];
        end
        expSumArea  = (ta > SMAX) ? SMAX : ta;
        expSumPerim = (tp > SMAX) ? SMAX : tp;
        expSat      = (ta > SMAX) || (tp > SMAX);
        expCount    = areaQ.size();
`ifdef CIRCLE_STATS_MAX_EN
        expMax = mx;
`else
        expMax = 0;
`endif
        holding = 1'b1;
        areaQ.delete();
        perimQ.delete();
    endtask

    task automatic checkState();
        checkOutput("in_ready", in_ready, !holding);
        checkOutput("out_valid", out_valid, holding);
        if (holding) begin
            checkOutput("sum_area", sum_area, expSumArea);
            checkOutput("sum_perim", sum_perim, expSumPerim);
            checkOutput("max_area", max_area, expMax);
            checkOutput("count", count, expCount);
            checkOutput("sat", sat, expSat);
        end
    endtask

    // Drives one cycle of inputs, advances the model over the edge, then checks.
    task automatic applyStimulus(input bit v, input bit last, input longint a, input longint p,
                                 input bit ordy, input bit clr);
        bit wasHolding;
        in_valid  = v;
        in_last   = last;
        area      = AW'(a);
        perimeter = AW'(p);
        out_ready = ordy;
        clear     = clr;
        wasHolding = holding;
        @(posedge clk);
        #1;
        if (clr) begin
            modelReset();
        end else if (v && !wasHolding) begin
            areaQ.push_back(a);
            perimQ.push_back(p);
            if (last || areaQ.size() == MAX_LEN) modelCloseFrame();
        end else if (wasHolding && ordy) begin
            holding = 1'b0;
        end
        checkState();
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(1'b0, 1'b0, 0, 0, ordy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        area = '0; perimeter = '0; out_ready = 1'b0;
        modelReset();
        #12;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sum_area", sum_area, 0);
        checkOutput("rst_sum_perim", sum_perim, 0);
        checkOutput("rst_max_area", max_area, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_sat", sat, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic frame and backpressure");
        applyStimulus(1, 0, 20106, 8042, 0, 0);
        applyStimulus(1, 0, 3218, 3217, 0, 0);
        applyStimulus(1, 1, 12870, 6434, 0, 0);
        checkOutput("basic_valid", out_valid, 1);
        checkOutput("basic_sum_area", sum_area, 36194);
        checkOutput("basic_sum_perim", sum_perim, 17693);
`ifdef CIRCLE_STATS_MAX_EN
        checkOutput("basic_max", max_area, 20106);
`else
        checkOutput("basic_max", max_area, 0);
`endif
        checkOutput("basic_count", count, 3);
        checkOutput("basic_sat", sat, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 777, 555, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("bp_release_ready", in_ready, 1);
        checkOutput("bp_release_valid", out_valid, 0);

        $display("[TB] equal areas and forced frame end");
        for (int i = 0; i < MAX_LEN; i++) applyStimulus(1, 0, 5000, 100 + i, 1, 0);
        checkOutput("forced_count", count, MAX_LEN);
        idle(1);

        $display("[TB] saturation then recovery");
        for (int i = 0; i < 5; i++) applyStimulus(1, i == 4, 24'hFFFFF0 - i, 24'hFFFFFF, 1, 0);
        checkOutput("sat_flag", sat, 1);
        checkOutput("sat_sum", sum_area, SMAX);
        idle(1);
        applyStimulus(1, 1, 10, 20, 1, 0);
        checkOutput("sat_cleared", sat, 0);
        idle(1);

        $display("[TB] clear mid-frame and while holding");
        applyStimulus(1, 0, 400, 40, 0, 0);
        applyStimulus(1, 0, 900, 90, 0, 1);
        applyStimulus(1, 1, 300, 30, 0, 0);
        checkOutput("clear_count", count, 1);
        applyStimulus(1, 0, 1, 1, 1, 1);
        checkOutput("clear_hold_valid", out_valid, 0);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 500; i++) begin
            longint a, p;
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(24'hF00000, 24'hFFFFFF)
                                            : $urandom_range(0, 65535);
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(24'hF00000, 24'hFFFFFF)
                                            : $urandom_range(0, 65535);
            if ($urandom_range(0, 2) == 0) p = a;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, a, p,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("[TB] async reset while holding");
        while (holding) idle(1);
        applyStimulus(1, 0, 11, 22, 0, 0);
        applyStimulus(1, 1, 33, 44, 0, 0);
        checkOutput("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_ready", in_ready, 1);
        checkOutput("async_rst_count", count, 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 50, 60, 1, 0);
        checkOutput("post_rst_count", count, 1);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
